barrido_columnas: RTL and testbench



---
 rtl/barrido_columnas.sv | 94 +++++++++
 tb/tb_barrido_columnas.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/barrido_columnas.sv
// -----------------------------------------------------------------------------
// barrido_columnas -- keypad column-scan generator
//
// Drives one column of a 4-column matrix keypad at a time. Each column stays
// active for SCAN_DIV clock cycles, and then the drive rotates to the next
// column (0 -> 1 -> 2 -> 3 -> 0). The row-sense and debounce logic uses
// col_idx and col_step to know which column is currently active.
//
// Parameters
//   SCAN_DIV  number of clock cycles each column stays active. Values below 1
//             are treated as 1.
//
// Ports
//   clk       in   1  system clock, rising-edge active
//   rst       in   1  asynchronous, active-high reset
//   hold      in   1  1 = freeze the scan on the current column
//   col       out  4  registered column drive, exactly one column active
//   col_idx   out  2  binary index of the active column, always matches col
//   col_step  out  1  one-cycle pulse in the first cycle a new column is active
//
// Configuration macro
//   BARRIDO_ACTIVE_LOW_EN  When defined, col is one-cold (active-low) for
//                          pull-up keypads: the reset value is 4'b1110 and the
//                          sequence is 1110, 1101, 1011, 0111. col_idx and
//                          col_step are the same in both builds.
// -----------------------------------------------------------------------------
module barrido_columnas #(
  parameter int SCAN_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic       col_step
);

  // A divide value of 0 (or less) behaves as 1.
  localparam int DIV   = (SCAN_DIV < 1) ? 1 : SCAN_DIV;
  localparam int CLOG  = $clog2(DIV + 1);
  localparam int CNT_W = (CLOG < 1) ? 1 : CLOG;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  // col_q is kept in the output polarity so that the col pin comes straight
  // from a flop. A left rotate works for both one-hot and one-cold patterns.
`ifdef BARRIDO_ACTIVE_LOW_EN
  localparam logic [3:0] COL_RST = 4'b1110;
`else
  localparam logic [3:0] COL_RST = 4'b0001;
`endif

  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       col_q,   col_d;
  logic [1:0]       idx_q,   idx_d;
  logic             step_q,  step_d;

  always_comb begin
    count_d = count_q;
    col_d   = col_q;
    idx_d   = idx_q;
    step_d  = 1'b0;
    if (hold) begin
      // Hold takes priority over the terminal count. The next advance then
      // comes a full SCAN_DIV period after hold drops.
      count_d = '0;
    end else if (count_q == CNT_LAST) begin
      count_d = '0;
      col_d   = {col_q[2:0], col_q[3]};
      idx_d   = idx_q + 2'd1;
      step_d  = 1'b1;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      col_q   <= COL_RST;
      idx_q   <= 2'd0;
      step_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
    end
  end

  assign col      = col_q;
  assign col_idx  = idx_q;
  assign col_step = step_q;

endmodule

// File: tb/tb_barrido_columnas.sv
// -----------------------------------------------------------------------------
// Testbench for barrido_columnas. Three instances (SCAN_DIV = 1, 2, 3) share
// clk, rst and hold. A reference model predicts the outputs of every instance
// after each rising edge and pushes the prediction into a queue. A separate
// monitor pops each prediction 1 ns after the edge and compares it with the
// instance outputs. The monitor also checks that an asynchronous reset takes
// effect between clock edges.
// -----------------------------------------------------------------------------
module tb_barrido_columnas;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic hold = 1'b0;

  logic [3:0] col_w  [3];
  logic [1:0] idx_w  [3];
  logic       step_w [3];

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  typedef struct packed {
    logic [2:0][3:0] col;
    logic [2:0][1:0] idx;
    logic [2:0]      step;
  } exp_t;

  exp_t exp_q[$];

  always #20 clk = ~clk;

  barrido_columnas #(.SCAN_DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .hold(hold),
    .col(col_w[0]), .col_idx(idx_w[0]), .col_step(step_w[0]));
  barrido_columnas #(.SCAN_DIV(2)) u_d2 (
    .clk(clk), .rst(rst), .hold(hold),
    .col(col_w[1]), .col_idx(idx_w[1]), .col_step(step_w[1]));
  barrido_columnas #(.SCAN_DIV(3)) u_d3 (
    .clk(clk), .rst(rst), .hold(hold),
    .col(col_w[2]), .col_idx(idx_w[2]), .col_step(step_w[2]));

  function automatic int div_of(input int i);
    return i + 1;
  endfunction

  // Returns the expected col pin value for a given column number.
  function automatic logic [3:0] pin_of(input int k);
    logic [3:0] v;
    v = 4'b0001 << k;
`ifdef BARRIDO_ACTIVE_LOW_EN
    v = ~v;
`endif
    return v;
  endfunction

  // The reference model. For each instance it tracks the active column
  // number and how many edges have elapsed since that column became
  // active (or since hold last released).
  int col_no  [3];
  int elapsed [3];
  bit fresh   [3];

  initial begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      col_no[i] = 0; elapsed[i] = 0; fresh[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          col_no[i] = 0; elapsed[i] = 0; fresh[i] = 1'b0;
        end else if (hold) begin
          elapsed[i] = 0; fresh[i] = 1'b0;
        end else begin
          elapsed[i] = elapsed[i] + 1;
          if (elapsed[i] == div_of(i)) begin
            col_no[i]  = (col_no[i] + 1) % 4;
            elapsed[i] = 0;
            fresh[i]   = 1'b1;
          end else begin
            fresh[i] = 1'b0;
          end
        end
        e.col[i]  = pin_of(col_no[i]);
        e.idx[i]  = 2'(col_no[i]);
        e.step[i] = fresh[i];
      end
      exp_q.push_back(e);
    end
  end

  // The monitor. It wakes on every rising edge of clk or rst.
  initial begin
    exp_t e;
    logic [3:0] norm;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (col_w[i] !== e.col[i] || idx_w[i] !== e.idx[i] || step_w[i] !== e.step[i]) begin
            failures++;
            $display("FAIL scan_div%0d t=%0t col/idx/step got %b/%0d/%b want %b/%0d/%b",
                     div_of(i), $time, col_w[i], idx_w[i], step_w[i],
                     e.col[i], e.idx[i], e.step[i]);
          end
`ifdef BARRIDO_ACTIVE_LOW_EN
          norm = ~col_w[i];
`else
          norm = col_w[i];
`endif
          checks++;
          if (!$onehot(norm) || norm !== (4'b0001 << idx_w[i])) begin
            failures++;
            $display("FAIL onehot_div%0d t=%0t col got %b idx %0d want single bit at idx",
                     div_of(i), $time, col_w[i], idx_w[i]);
          end
        end
      end else if (rst && !done) begin
        // This is a reset assertion between edges. The outputs must already
        // hold their reset values.
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (col_w[i] !== pin_of(0) || idx_w[i] !== 2'd0 || step_w[i] !== 1'b0) begin
            failures++;
            $display("FAIL async_rst_div%0d t=%0t col/idx/step got %b/%0d/%b want %b/0/0",
                     div_of(i), $time, col_w[i], idx_w[i], step_w[i], pin_of(0));
          end
        end
      end
    end
  end

  task automatic pulse_async_reset();
    @(negedge clk);
    #10 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int burst;
    // Power-on reset, then release it on a falling edge.
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Run freely through several full rotations.
    repeat (24) @(negedge clk);

    // Apply a long hold, then release it.
    hold = 1'b1;
    repeat (10) @(negedge clk);
    hold = 1'b0;
    repeat (8) @(negedge clk);

    // Assert reset mid-scan, then let the scan resume.
    pulse_async_reset();
    repeat (12) @(negedge clk);

    // Random hold patterns with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 2) begin
        rst = 1'b0;
        hold = 1'b0;
        pulse_async_reset();
      end else begin
        burst = $urandom_range(0, 99);
        hold = (burst < 25);
      end
    end

    hold = 1'b0;
    repeat (4) @(negedge clk);
    done = 1'b1;
    @(posedge clk);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so that a stuck run still produces a result.
  initial begin
    #(40 * 5000);
    failures++;
    $display("FAIL timeout t=%0t got no completion want finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
